dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 is the core's load/store

---
 rtl/dmem_port_arbiter_pkg.sv | 22 ++
 rtl/dmem_port_arbiter_if.sv | 25 ++
 rtl/dmem_port_arbiter_starve_ctr.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Requester identities: core load/store unit and program/data loader.
  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LOAD = 1'b1
  } port_id_e;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: command in, grant/response out.
interface dmem_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester side drives the command and observes grant/response.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side accepts the command and returns grant/response.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating loss counter for the low-priority port; raises force_o once the
// loader has lost STARVE_LIM arbitrations in a row.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  localparam int CW = cnt_width(STARVE_LIM);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < CW'(STARVE_LIM))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q >= CW'(STARVE_LIM));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of the single-port data memory. Port 0 (core)
// has fixed priority, port 1 (loader) is forced through after repeated losses.
// One transaction in flight: IDLE -> ISSUE -> (WAIT for reads) -> IDLE.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_req_if.slave         port0,
  dmem_req_if.slave         port1,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int WAIT_W = cnt_width(RD_LAT);

  arb_state_e        state_q,      state_d;
  port_id_e          port_q,       port_d;
  logic              held_we_q,    held_we_d;
  logic [ADDR_W-1:0] held_addr_q,  held_addr_d;
  logic [DATA_W-1:0] held_wdata_q, held_wdata_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic              gnt0_q,       gnt0_d;
  logic              gnt1_q,       gnt1_d;
  logic              rvalid0_q,    rvalid0_d;
  logic              rvalid1_q,    rvalid1_d;
  logic [DATA_W-1:0] rdata0_q,     rdata0_d;
  logic [DATA_W-1:0] rdata1_q,     rdata1_d;

  logic starve_inc;
  logic starve_clr;
  logic starve_force;
  logic pick_load;

  // Loader wins when it is alone, or when it has been starved long enough.
  assign pick_load = port1.req && (!port0.req || starve_force);

  dmem_arb_starve_ctr #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (starve_inc),
    .clr_i  (starve_clr),
    .force_o(starve_force)
  );

  // Next-state, arbitration, command latch and response capture.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    held_we_d    = held_we_q;
    held_addr_d  = held_addr_q;
    held_wdata_d = held_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (port0.req || port1.req) begin
          state_d = ST_ISSUE;
          if (pick_load) begin
            port_d       = PORT_LOAD;
            held_we_d    = port1.we;
            held_addr_d  = port1.addr;
            held_wdata_d = port1.wdata;
            gnt1_d       = 1'b1;
            starve_clr   = 1'b1;
          end else begin
            port_d       = PORT_CORE;
            held_we_d    = port0.we;
            held_addr_d  = port0.addr;
            held_wdata_d = port0.wdata;
            gnt0_d       = 1'b1;
            // Only a loss against a waiting loader counts as starvation.
            starve_inc   = port1.req;
          end
        end
      end

      ST_ISSUE: begin
        if (held_we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(RD_LAT);
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == WAIT_W'(1)) begin
          state_d = ST_IDLE;
          if (port_q == PORT_LOAD) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_rdata_i;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_rdata_i;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and in-flight bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_CORE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Held command: drives the memory address/data during ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_we_q    <= 1'b0;
      held_addr_q  <= '0;
      held_wdata_q <= '0;
    end else begin
      held_we_q    <= held_we_d;
      held_addr_q  <= held_addr_d;
      held_wdata_q <= held_wdata_d;
    end
  end

  // Grant and read-response registers; rdata holds until that port's next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Strobes decode straight from the state register so a reset kills them at once.
  assign mem_we_o    = (state_q == ST_ISSUE) &&  held_we_q;
  assign mem_re_o    = (state_q == ST_ISSUE) && !held_we_q;
  assign mem_addr_o  = held_addr_q;
  assign mem_wdata_o = held_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

  assign port0.gnt    = gnt0_q;
  assign port1.gnt    = gnt1_q;
  assign port0.rvalid = rvalid0_q;
  assign port1.rvalid = rvalid1_q;
  assign port0.rdata  = rdata0_q;
  assign port1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two arbiter lanes (RD_LAT 1 and 3) each with a
// behavioural memory; read responses are scoreboarded through a queue.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LIM  = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    int            ln;
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   starve_m [2];
  exp_t exp_q [$];

  logic [1:0][1:0]         req_s;
  logic [1:0][1:0]         we_s;
  logic [1:0][1:0][AW-1:0] addr_s;
  logic [1:0][1:0][DW-1:0] wdata_s;
  wire  [1:0][1:0]         gnt_s;
  wire  [1:0][1:0]         rvalid_s;
  wire  [1:0][1:0][DW-1:0] rdata_s;
  wire  [1:0]              mem_re_s;
  wire  [1:0]              mem_we_s;
  wire  [1:0]              busy_s;
  wire  [1:0][AW-1:0]      mem_addr_s;
  wire  [1:0][DW-1:0]      mem_wdata_s;
  wire  [1:0][DW-1:0]      mem_rdata_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int LAT = (gi == 0) ? LAT0 : LAT1;

    dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if0.req   = req_s[gi][0];
    assign if0.we    = we_s[gi][0];
    assign if0.addr  = addr_s[gi][0];
    assign if0.wdata = wdata_s[gi][0];
    assign if1.req   = req_s[gi][1];
    assign if1.we    = we_s[gi][1];
    assign if1.addr  = addr_s[gi][1];
    assign if1.wdata = wdata_s[gi][1];
    assign gnt_s[gi][0]    = if0.gnt;
    assign gnt_s[gi][1]    = if1.gnt;
    assign rvalid_s[gi][0] = if0.rvalid;
    assign rvalid_s[gi][1] = if1.rvalid;
    assign rdata_s[gi][0]  = if0.rdata;
    assign rdata_s[gi][1]  = if1.rdata;

    dmem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_LIM(LIM)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .port0      (if0),
      .port1      (if1),
      .mem_re_o   (mem_re_s[gi]),
      .mem_we_o   (mem_we_s[gi]),
      .mem_addr_o (mem_addr_s[gi]),
      .mem_wdata_o(mem_wdata_s[gi]),
      .mem_rdata_i(mem_rdata_s[gi]),
      .busy_o     (busy_s[gi])
    );

    // Memory model: data appears LAT cycles after the read strobe, zero otherwise.
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [LAT];
    initial begin
      for (int k = 0; k < 256; k++) mem[k] = '0;
      for (int k = 0; k < LAT; k++) pipe[k] = '0;
    end
    always @(posedge clk) begin
      if (mem_we_s[gi]) mem[mem_addr_s[gi][9:2]] <= mem_wdata_s[gi];
      pipe[0] <= mem_re_s[gi] ? mem[mem_addr_s[gi][9:2]] : '0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata_s[gi] = pipe[LAT-1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Issue one command and wait (bounded) for its grant; reads enqueue their response.
  task automatic do_txn(input int ln, input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd_exp, output int gcyc);
    int   t;
    exp_t e;
    req_s[ln][p]   = 1'b1;
    we_s[ln][p]    = w;
    addr_s[ln][p]  = a;
    wdata_s[ln][p] = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt_s[ln][p] && t < 50);
    check_eq("gnt_seen", gnt_s[ln][p], 1'b1);
    gcyc = cyc;
    if (p == 1) starve_m[ln] = 0;
    if (!w && gnt_s[ln][p]) begin
      e.ln   = ln;
      e.port = p;
      e.data = rd_exp;
      e.cyc  = cyc + 1 + ((ln == 0) ? LAT0 : LAT1);
      exp_q.push_back(e);
    end
    $display("txn lane%0d port%0d %s addr=%h wdata=%h gnt_cyc=%0d", ln, p, w ? "WR" : "RD", a, d, cyc);
    req_s[ln][p] = 1'b0;
  endtask

  // Wait (bounded) until every queued response has arrived and the lanes are idle.
  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_s[0] || busy_s[1]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  // Hold both ports' write requests and check the grant order against the starvation model.
  task automatic contend(input int ln, input int n);
    int got;
    int t;
    int exp_port;
    req_s[ln]   = 2'b11;
    we_s[ln]    = 2'b11;
    addr_s[ln][0] = 32'h100;
    addr_s[ln][1] = 32'h200;
    got = 0;
    t   = 0;
    while (got < n && t < 200) begin
      @(negedge clk);
      t++;
      if (gnt_s[ln][0] | gnt_s[ln][1]) begin
        exp_port = (starve_m[ln] >= LIM) ? 1 : 0;
        check_eq("arb_port", gnt_s[ln][1], exp_port[0]);
        $display("txn lane%0d arb grant port%0d cyc=%0d", ln, gnt_s[ln][1], cyc);
        if (exp_port == 1) starve_m[ln] = 0;
        else if (starve_m[ln] < LIM) starve_m[ln]++;
        got++;
        if (got == n) req_s[ln] = 2'b00;
      end
    end
    req_s[ln] = 2'b00;
    check_eq("arb_count", got, n);
  endtask

  // Protocol invariants and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int ln = 0; ln < 2; ln++) begin
        if (mem_re_s[ln] | mem_we_s[ln]) begin
          check_eq("strobe_excl", mem_re_s[ln] & mem_we_s[ln], 1'b0);
          check_eq("strobe_with_gnt", gnt_s[ln][0] | gnt_s[ln][1], 1'b1);
        end
        if (gnt_s[ln][0] | gnt_s[ln][1])
          check_eq("gnt_excl", gnt_s[ln][0] & gnt_s[ln][1], 1'b0);
        if (rvalid_s[ln][0] | rvalid_s[ln][1])
          check_eq("rvalid_excl", rvalid_s[ln][0] & rvalid_s[ln][1], 1'b0);
        for (int p = 0; p < 2; p++) begin
          if (rvalid_s[ln][p]) begin
            if (exp_q.size() == 0) begin
              check_eq("rvalid_unexpected", rvalid_s[ln][p], 1'b0);
            end else begin
              e = exp_q.pop_front();
              check_eq("rv_lane", ln, e.ln);
              check_eq("rv_port", p, e.port);
              check_eq("rv_data", rdata_s[ln][p], e.data);
              check_eq("rv_cycle", cyc, e.cyc);
              $display("txn lane%0d port%0d RSP rdata=%h cyc=%0d", ln, p, rdata_s[ln][p], cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int c0;
    int gprev;
    int n;
    req_s   = '0;
    we_s    = '0;
    addr_s  = '0;
    wdata_s = '0;
    starve_m[0] = 0;
    starve_m[1] = 0;
    reset   = 1'b1;

    // 1: reset state with no requests
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", {gnt_s[0][0], gnt_s[0][1]}, 2'b00);
    check_eq("rst_rvalid", {rvalid_s[0][0], rvalid_s[0][1]}, 2'b00);
    check_eq("rst_strobes", {mem_re_s[0], mem_we_s[0]}, 2'b00);
    check_eq("rst_busy", busy_s[0], 1'b0);
    check_eq("rst_addr", mem_addr_s[0], 0);
    check_eq("rst_wdata", mem_wdata_s[0], 0);
    check_eq("rst_rdata", {rdata_s[0][0], rdata_s[0][1]}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", busy_s[0], 1'b0);
    check_eq("idle_gnt", {gnt_s[0][0], gnt_s[0][1]}, 2'b00);

    // 1b: reset asserted during ISSUE of a write aborts it
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 32'h40; wdata_s[0][0] = 32'h1234;
    @(negedge clk);
    check_eq("abort_pre_gnt", gnt_s[0][0], 1'b1);
    check_eq("abort_pre_we", mem_we_s[0], 1'b1);
    reset = 1'b1;
    #1;
    check_eq("abort_we_drop", mem_we_s[0], 1'b0);
    check_eq("abort_gnt_drop", gnt_s[0][0], 1'b0);
    check_eq("abort_busy_drop", busy_s[0], 1'b0);
    req_s[0][0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    starve_m[0] = 0;
    starve_m[1] = 0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(gnt_s[0][0] | gnt_s[0][1]);
    end
    check_eq("abort_no_gnt", n, 0);

    // 2: port-0 write
    c0 = cyc;
    do_txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, g);
    check_eq("wr_gnt_lat", g, c0 + 1);
    check_eq("wr_mem_we", {mem_we_s[0], mem_re_s[0]}, 2'b10);
    check_eq("wr_mem_addr", mem_addr_s[0], 32'h10);
    check_eq("wr_mem_wdata", mem_wdata_s[0], 32'hDEADBEEF);
    check_eq("wr_busy", busy_s[0], 1'b1);
    @(negedge clk);
    check_eq("wr_busy_done", busy_s[0], 1'b0);
    check_eq("wr_we_done", mem_we_s[0], 1'b0);

    // 3: port-1 read of the same address, RD_LAT=1
    c0 = cyc;
    do_txn(0, 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, g);
    check_eq("rd_gnt_lat", g, c0 + 1);
    check_eq("rd_mem_re", {mem_we_s[0], mem_re_s[0]}, 2'b01);
    drain();
    repeat (2) @(negedge clk);
    check_eq("rd_rdata_hold", rdata_s[0][1], 32'hDEADBEEF);
    check_eq("rd_rdata0_untouched", rdata_s[0][0], 32'h0);

    // 4: continuous contention
    contend(0, 10);
    drain();

    // 5: back-to-back port-0 reads on the RD_LAT=3 lane
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 0, 1'b1, 32'h20 + 32'(4 * k), 32'hA5A50000 + 32'(k), 32'h0, g);
    end
    @(negedge clk);
    gprev = 0;
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 0, 1'b0, 32'h20 + 32'(4 * k), 32'h0, 32'hA5A50000 + 32'(k), g);
      if (k > 0) check_eq("b2b_gnt_spacing", g - gprev, LAT1 + 2);
      gprev = g;
    end
    drain();

    // 6: port-1 request raised and dropped while port 0 waits for read data
    do_txn(1, 0, 1'b0, 32'h24, 32'h0, 32'hA5A50001, g);
    @(negedge clk);
    req_s[1][1] = 1'b1; we_s[1][1] = 1'b1; addr_s[1][1] = 32'h80;
    @(negedge clk);
    @(negedge clk);
    check_eq("drop_in_wait", busy_s[1], 1'b1);
    req_s[1][1] = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(gnt_s[1][1]);
    end
    check_eq("drop_not_served", n, 0);
    drain();
    contend(1, 5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
